// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: two-stage SECDED Hamming decoder with a valid/ready
// handshake and optional saturating error counters.
//
// Codeword layout: bit i-1 of ip_code holds Hamming position i. Parity bits
// occupy the power-of-two positions and data bits fill the remaining
// positions in ascending order, d0 first. ip_par is the overall even parity
// over the whole word.
//
// Ports
//   ip_clk, ip_rst        clock and synchronous active-high reset
//   ip_code, ip_par       codeword and overall parity bit
//   ip_valid / ip_ready   input handshake (ip_ready = pipeline advance enable)
//   op_data               decoded data, corrected where possible
//   op_syndrome           raw syndrome of the word
//   op_sec / op_ded       single error corrected / uncorrectable error seen
//   op_valid / op_ready   output handshake
//   ip_cnt_clr            clear both error counters
//   op_sec_cnt/op_ded_cnt saturating counts of corrected / uncorrectable words
//
// Build option: define HAMM_ERR_CNT_EN to include the error counters. Without
// it the counter outputs are tied to zero and ip_cnt_clr is ignored.
module hamming_secded_pipe #(
  parameter int DW    = 4,
  parameter int CNT_W = 16,
  // Fixed-point iteration of PW = clog2(DW+PW+1); it converges from below to
  // the smallest solution within two steps over the legal DW range.
  localparam int PW0  = $clog2(DW + 1),
  localparam int PW1  = $clog2(DW + PW0 + 1),
  localparam int PW   = $clog2(DW + PW1 + 1),
  localparam int N    = DW + PW
) (
  input  logic             ip_clk,
  input  logic             ip_rst,
  input  logic [N-1:0]     ip_code,
  input  logic             ip_par,
  input  logic             ip_valid,
  output logic             ip_ready,
  output logic [DW-1:0]    op_data,
  output logic [PW-1:0]    op_syndrome,
  output logic             op_sec,
  output logic             op_ded,
  output logic             op_valid,
  input  logic             op_ready,
  input  logic             ip_cnt_clr,
  output logic [CNT_W-1:0] op_sec_cnt,
  output logic [CNT_W-1:0] op_ded_cnt
);

  // XOR of the position indices of every set bit.
  function automatic logic [PW-1:0] syndrome(input logic [N-1:0] c);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 1; i <= N; i++)
      if (c[i-1]) s = s ^ PW'(i);
    return s;
  endfunction

  // Gather the bits at non-power-of-two positions, lowest position first.
  function automatic logic [DW-1:0] extract(input logic [N-1:0] c);
    logic [DW-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i <= N; i++)
      if ((i & (i - 1)) != 0) begin
        d[k] = c[i-1];
        k++;
      end
    return d;
  endfunction

  logic en;

  logic          vld_p1_q, vld_p1_d;
  logic [PW-1:0] syn_p1_q, syn_p1_d;
  logic          g_p1_q,   g_p1_d;
  logic [N-1:0]  code_p1_q, code_p1_d;

  logic          vld_p2_q, vld_p2_d;
  logic [DW-1:0] data_p2_q, data_p2_d;
  logic [PW-1:0] syn_p2_q, syn_p2_d;
  logic          sec_p2_q, sec_p2_d;
  logic          ded_p2_q, ded_p2_d;

  logic [N-1:0]  code_fix;
  logic          in_range;
  logic          sec_dec, ded_dec;

  assign en       = !vld_p2_q || op_ready;
  assign ip_ready = en;

  // Decode from stage-1 registers. A syndrome beyond N cannot name a real
  // position, so it is treated as uncorrectable even when G flags one error.
  always_comb begin
    in_range = (int'(syn_p1_q) <= N);
    sec_dec  = g_p1_q && in_range;
    ded_dec  = (syn_p1_q != '0) && !sec_dec;
    code_fix = code_p1_q;
    for (int i = 1; i <= N; i++)
      if (g_p1_q && (syn_p1_q == PW'(i))) code_fix[i-1] = ~code_p1_q[i-1];
  end

  always_comb begin
    vld_p1_d  = vld_p1_q;
    syn_p1_d  = syn_p1_q;
    g_p1_d    = g_p1_q;
    code_p1_d = code_p1_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    syn_p2_d  = syn_p2_q;
    sec_p2_d  = sec_p2_q;
    ded_p2_d  = ded_p2_q;
    if (en) begin
      vld_p1_d  = ip_valid;
      syn_p1_d  = syndrome(ip_code);
      g_p1_d    = ^ip_code ^ ip_par;
      code_p1_d = ip_code;
      vld_p2_d  = vld_p1_q;
      data_p2_d = extract(code_fix);
      syn_p2_d  = syn_p1_q;
      sec_p2_d  = sec_dec;
      ded_p2_d  = ded_dec;
    end
  end

  // ---- stage 1: syndrome, overall check, raw codeword ----
  always_ff @(posedge ip_clk) begin
    syn_p1_q  <= syn_p1_d;
    g_p1_q    <= g_p1_d;
    code_p1_q <= code_p1_d;
  end

  // ---- stage 2: decoded outputs; valids and outputs cleared by reset ----
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      syn_p2_q  <= '0;
      sec_p2_q  <= 1'b0;
      ded_p2_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      syn_p2_q  <= syn_p2_d;
      sec_p2_q  <= sec_p2_d;
      ded_p2_q  <= ded_p2_d;
    end
  end

  assign op_valid    = vld_p2_q;
  assign op_data     = data_p2_q;
  assign op_syndrome = syn_p2_q;
  assign op_sec      = sec_p2_q;
  assign op_ded      = ded_p2_q;

`ifdef HAMM_ERR_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic             out_hs;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

  assign out_hs = vld_p2_q && op_ready;

  // Clear wins over a same-cycle increment.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (ip_cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (out_hs) begin
      if (sec_p2_q) sec_cnt_d = sat_inc(sec_cnt_q);
      if (ded_p2_q) ded_cnt_d = sat_inc(ded_cnt_q);
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign op_sec_cnt = sec_cnt_q;
  assign op_ded_cnt = ded_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = ip_cnt_clr;
  assign op_sec_cnt     = '0;
  assign op_ded_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench for hamming_secded_pipe at DW=4 (PW=3, N=7) with 2-bit counters.
// Expected words come from encoding known data and injecting a known number
// of errors; a queue of pending words with their advance-cycle age gives the
// expected output timing and order.
module tb_hamming_secded_pipe;
  localparam int DW    = 4;
  localparam int CNT_W = 2;
  localparam int PW    = 3;
  localparam int N     = 7;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAMM_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             ip_clk = 1'b0;
  logic             ip_rst;
  logic [N-1:0]     ip_code;
  logic             ip_par;
  logic             ip_valid;
  logic             ip_ready;
  logic [DW-1:0]    op_data;
  logic [PW-1:0]    op_syndrome;
  logic             op_sec;
  logic             op_ded;
  logic             op_valid;
  logic             op_ready;
  logic             ip_cnt_clr;
  logic [CNT_W-1:0] op_sec_cnt;
  logic [CNT_W-1:0] op_ded_cnt;

  hamming_secded_pipe #(.DW(DW), .CNT_W(CNT_W)) dut (
    .ip_clk(ip_clk), .ip_rst(ip_rst), .ip_code(ip_code), .ip_par(ip_par),
    .ip_valid(ip_valid), .ip_ready(ip_ready), .op_data(op_data),
    .op_syndrome(op_syndrome), .op_sec(op_sec), .op_ded(op_ded),
    .op_valid(op_valid), .op_ready(op_ready), .ip_cnt_clr(ip_cnt_clr),
    .op_sec_cnt(op_sec_cnt), .op_ded_cnt(op_ded_cnt)
  );

  always #5 ip_clk = ~ip_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] syn;
    bit            sec;
    bit            ded;
    int            age;
  } exp_t;

  exp_t q[$];
  int   sec_cnt_m = 0;
  int   ded_cnt_m = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] d, input logic [PW-1:0] s,
                              input bit sec, input bit ded);
    exp_t e;
    e.data = d; e.syn = s; e.sec = sec; e.ded = ded; e.age = 0;
    return e;
  endfunction

  function automatic logic [PW-1:0] ref_syn(input logic [N-1:0] c);
    logic [PW-1:0] s = '0;
    for (int i = 1; i <= N; i++) if (c[i-1]) s ^= PW'(i);
    return s;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p == 1) || (p == 2) || (p == 4) || (p == 8) || (p == 16) || (p == 32);
  endfunction

  function automatic logic [N-1:0] encode(input logic [DW-1:0] d);
    logic [N-1:0]  c = '0;
    logic [PW-1:0] s;
    int k = 0;
    for (int p = 1; p <= N; p++)
      if (!is_pow2(p)) begin c[p-1] = d[k]; k++; end
    s = ref_syn(c);
    for (int b = 0; b < PW; b++) c[(1 << b) - 1] = s[b];
    return c;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [N-1:0] c);
    logic [DW-1:0] d = '0;
    int k = 0;
    for (int p = 1; p <= N; p++)
      if (!is_pow2(p)) begin d[k] = c[p-1]; k++; end
    return d;
  endfunction

  // Random data word with 0, 1 or 2 distinct flips; flip slot 0 is ip_par.
  task automatic gen_word(output logic [N-1:0] c, output bit p, output exp_t e);
    logic [DW-1:0] d;
    int nerr, a, b;
    d = DW'($urandom);
    c = encode(d);
    p = ^c;
    nerr = $urandom_range(0, 2);
    a = $urandom_range(0, N);
    b = (a + $urandom_range(1, N)) % (N + 1);
    if (nerr >= 1) begin if (a == 0) p = ~p; else c[a-1] = ~c[a-1]; end
    if (nerr == 2) begin if (b == 0) p = ~p; else c[b-1] = ~c[b-1]; end
    e = mk((nerr == 2) ? data_of(c) : d, ref_syn(c), nerr == 1, nerr == 2);
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic cycle(input bit rst, input bit v, input bit rdy, input bit clr,
                       input logic [N-1:0] code, input bit par, input exp_t e,
                       output bit acc);
    bit   ev;
    exp_t f;
    exp_t n;
    @(negedge ip_clk);
    ip_rst = rst; ip_valid = v; op_ready = rdy; ip_cnt_clr = clr;
    ip_code = code; ip_par = par;
    #1;
    ev = (q.size() > 0) && (q[0].age >= 2);
    chk("op_valid", op_valid, ev);
    chk("ip_ready", ip_ready, !ev || rdy);
    if (ev) begin
      f = q[0];
      chk("op_data", op_data, f.data);
      chk("op_syndrome", op_syndrome, f.syn);
      chk("op_sec", op_sec, f.sec);
      chk("op_ded", op_ded, f.ded);
    end
    chk("op_sec_cnt", op_sec_cnt, sec_cnt_m);
    chk("op_ded_cnt", op_ded_cnt, ded_cnt_m);
    acc = v && (!ev || rdy);
    if (rst) begin
      q.delete();
      sec_cnt_m = 0;
      ded_cnt_m = 0;
    end else begin
      if (CNT_EN) begin
        if (clr) begin
          sec_cnt_m = 0; ded_cnt_m = 0;
        end else if (ev && rdy) begin
          if (f.sec && sec_cnt_m < CMAX) sec_cnt_m++;
          if (f.ded && ded_cnt_m < CMAX) ded_cnt_m++;
        end
      end
      if (ev && rdy) void'(q.pop_front());
      if (!ev || rdy) begin
        foreach (q[i]) q[i].age++;
        if (acc) begin n = e; n.age = 1; q.push_back(n); end
      end
    end
  endtask

  task automatic idle(input bit rdy);
    bit dmy;
    cycle(1'b0, 1'b0, rdy, 1'b0, '0, 1'b0, mk('0, '0, 1'b0, 1'b0), dmy);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin idle(1'b1); n++; end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit            acc;
    logic [N-1:0]  c;
    bit            p;
    exp_t          e;
    int            sent, cyc;

    ip_rst = 1'b1; ip_valid = 1'b0; op_ready = 1'b1; ip_cnt_clr = 1'b0;
    ip_code = '0; ip_par = 1'b0;
    repeat (2) @(posedge ip_clk);
    @(negedge ip_clk); #1;
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_data", op_data, 0);
    chk("rst_op_syndrome", op_syndrome, 0);
    chk("rst_op_sec", op_sec, 0);
    chk("rst_op_ded", op_ded, 0);
    chk("rst_ip_ready", ip_ready, 1);
    chk("rst_sec_cnt", op_sec_cnt, 0);
    chk("rst_ded_cnt", op_ded_cnt, 0);

    // Directed decode cases
    cycle(0, 1, 1, 0, 7'h55, 1'b0, mk(4'hB, 3'd0, 0, 0), acc);
    cycle(0, 1, 1, 0, 7'h45, 1'b0, mk(4'hB, 3'd5, 1, 0), acc);
    cycle(0, 1, 1, 0, 7'h56, 1'b0, mk(4'hB, 3'd3, 0, 1), acc);
    cycle(0, 1, 1, 0, 7'h55, 1'b1, mk(4'hB, 3'd0, 1, 0), acc);
    drain();

    // Four back-to-back words with downstream stalled for three cycles
    sent = 0; cyc = 0;
    while (sent < 4 && cyc < 20) begin
      c = encode(DW'(sent + 3));
      cycle(0, 1, !(cyc >= 1 && cyc <= 3), 0, c, ^c,
            mk(DW'(sent + 3), '0, 0, 0), acc);
      if (acc) sent++;
      cyc++;
    end
    chk("stall_sent", sent, 4);
    drain();

    // Counter saturation, then clear coincident with a sixth error word
    repeat (5) cycle(0, 1, 1, 0, 7'h45, 1'b0, mk(4'hB, 3'd5, 1, 0), acc);
    drain();
    chk("sec_cnt_sat", op_sec_cnt, CNT_EN ? CMAX : 0);
    cycle(0, 1, 1, 1, 7'h45, 1'b0, mk(4'hB, 3'd5, 1, 0), acc);
    idle(1'b1);
    chk("sec_cnt_clr", op_sec_cnt, 0);
    drain();

    // Reset with two words in flight; they must never emerge
    cycle(0, 1, 1, 0, 7'h55, 1'b0, mk(4'hB, 3'd0, 0, 0), acc);
    cycle(0, 1, 1, 0, 7'h45, 1'b0, mk(4'hB, 3'd5, 1, 0), acc);
    cycle(1, 1, 1, 0, 7'h56, 1'b0, mk(4'hB, 3'd3, 0, 1), acc);
    idle(1'b1);
    chk("rst_flush_valid", op_valid, 0);
    chk("rst_flush_ready", ip_ready, 1);
    repeat (3) idle(1'b1);

    // Randomised traffic with random back-pressure, clears and resets
    for (int i = 0; i < 600; i++) begin
      gen_word(c, p, e);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, c, p, e, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_secded_pipe.md
HAMMING_SECDED_PIPE -- requirements
Module: hamming_secded_pipe

Interface
REQ-001 SHALL have parameter DW, default 4, data width in bits, legal range 4..57.
REQ-002 SHALL have parameter CNT_W, default 16, width of each error counter, legal range 2..32.
REQ-003 SHALL derive localparam PW as the smallest integer with 2^PW >= DW+PW+1, and localparam N as DW+PW.
REQ-004 SHALL have port ip_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port ip_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ip_code, input, N bits: Hamming codeword; bit i-1 holds position i; parity bits sit at power-of-two positions; data bits fill the remaining positions in ascending order, d0 first.
REQ-007 SHALL have port ip_par, input, 1 bit: overall even parity, so that XOR of ip_code and ip_par is 0 when error-free.
REQ-008 SHALL have port ip_valid, input, 1 bit: ip_code and ip_par are valid.
REQ-009 SHALL have port ip_ready, output, 1 bit: block accepts an input word this cycle.
REQ-010 SHALL have port op_data, output, DW bits: decoded data, corrected where possible.
REQ-011 SHALL have port op_syndrome, output, PW bits: raw syndrome for the word.
REQ-012 SHALL have port op_sec, output, 1 bit: a single error was corrected.
REQ-013 SHALL have port op_ded, output, 1 bit: an uncorrectable error was detected.
REQ-014 SHALL have port op_valid, output, 1 bit: outputs hold a decoded word.
REQ-015 SHALL have port op_ready, input, 1 bit: downstream accepts the word.
REQ-016 SHALL have port ip_cnt_clr, input, 1 bit: synchronous clear of both counters.
REQ-017 SHALL have port op_sec_cnt, output, CNT_W bits: count of corrected words.
REQ-018 SHALL have port op_ded_cnt, output, CNT_W bits: count of uncorrectable words.

Function
REQ-019 SHALL define the advance enable en = !op_valid || op_ready, and SHALL drive ip_ready = en.
REQ-020 SHALL use a 2-stage pipeline: stage 1 registers the syndrome S, the overall check G = ^ip_code ^ ip_par, and the codeword; stage 2 registers the decoded outputs.
REQ-021 SHALL produce each accepted word (ip_valid && ip_ready) on the outputs exactly 2 en-cycles later, in order, with no loss or duplication.
REQ-022 SHALL let stage 1 and stage 2 advance only when en=1; when en=0, all stage registers and all outputs SHALL hold.
REQ-023 SHALL compute S as the XOR of the position indices of all set bits of ip_code.
REQ-024 SHALL decode S=0, G=0 as no error: op_sec=0, op_ded=0.
REQ-025 SHALL decode S=0, G=1 as an error in the parity bit: op_sec=1, data unchanged.
REQ-026 SHALL decode S in 1..N with G=1 by inverting codeword position S before data extraction, and SHALL set op_sec=1.
REQ-027 SHALL decode S!=0 with G=0, or S>N, as uncorrectable: op_ded=1, op_sec=0, and op_data carries the uncorrected extracted data.
REQ-028 SHALL increment each counter by 1 for each word that completes the output handshake (op_valid && op_ready) with the matching flag set, and SHALL saturate each counter at 2^CNT_W-1.
REQ-029 SHALL give ip_cnt_clr priority over a simultaneous increment, so that the counter reads 0 on the next cycle.

Reset
REQ-030 SHALL, on ip_rst, clear on the next edge: op_valid, op_sec, op_ded, op_data, op_syndrome, both counters, and the stage-1 valid.
REQ-031 SHALL discard all in-flight words when reset is asserted mid-operation.
REQ-032 SHALL hold ip_ready=1 during and after reset.

Configuration
REQ-033 SHALL, with macro HAMM_ERR_CNT_EN defined, include the counters as specified in REQ-028 and REQ-029.
REQ-034 SHALL, without HAMM_ERR_CNT_EN, tie op_sec_cnt and op_ded_cnt to 0, ignore ip_cnt_clr, and synthesise no counter flops.

Verification
REQ-035 SHALL cover, at DW=4: ip_code=7'h55, ip_par=0 -> 2 cycles later op_data=4'hB, op_syndrome=0, op_sec=0, op_ded=0.
REQ-036 SHALL cover: ip_code=7'h45, ip_par=0 -> op_data=4'hB, op_syndrome=5, op_sec=1, op_ded=0.
REQ-037 SHALL cover: ip_code=7'h56, ip_par=0 -> op_syndrome=3, op_ded=1, op_sec=0, op_data=4'hB; and ip_code=7'h55, ip_par=1 -> op_syndrome=0, op_sec=1.
REQ-038 SHALL cover back-to-back input of 4 words with op_ready=0 for 3 cycles -> ip_ready=0 while stalled, outputs held, all 4 words emitted in order.
REQ-039 SHALL cover, with HAMM_ERR_CNT_EN and CNT_W=2: 5 accepted single-error words -> op_sec_cnt=3 (saturated); then ip_cnt_clr coincident with a sixth single-error word -> op_sec_cnt=0.
REQ-040 SHALL cover ip_rst asserted with 2 words in flight -> next cycle op_valid=0, and the discarded words never appear.
